// File: rtl/mcc_pkg.sv
// Shared types for the multi-cycle MIPS controller: FSM states, instruction
// classes, opcode/funct values, datapath select encodings and the control bundle.
package mcc_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_ADDR,
    S_MEM_RD, S_WB_LD, S_MEM_WR, S_BR, S_J, S_JR, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_JR, C_JALR, C_IALU, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JAL, C_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_RS    = 2'b01;
  localparam logic [1:0] A_SHAMT = 2'b10;

  localparam logic [1:0] B_RT    = 2'b00;
  localparam logic [1:0] B_FOUR  = 2'b01;
  localparam logic [1:0] B_IMM   = 2'b10;
  localparam logic [1:0] B_IMMSH = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OPCODE = 2'b11;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src1;
    logic [1:0] alu_src2;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       lu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mcc_decode.sv
// Combinational OpCode/Funct classifier for the controller FSM; zero latency,
// no handshake. bne decodes as illegal when ENABLE_BNE is 0.
module mcc_decode
  import mcc_pkg::*;
#(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output iclass_t    iClass,
  output logic       extOp,
  output logic       luOp,
  output logic       isShift
);

  always_comb begin
    iClass  = C_ILLEGAL;
    extOp   = (OpCode != OP_ANDI);
    luOp    = (OpCode == OP_LUI);
    isShift = (Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA);
    case (OpCode)
      OP_RTYPE: begin
        if (Funct == FN_JR)        iClass = C_JR;
        else if (Funct == FN_JALR) iClass = C_JALR;
        else                       iClass = C_RTYPE;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: iClass = C_IALU;
      OP_LW:  iClass = C_LW;
      OP_SW:  iClass = C_SW;
      OP_BEQ: iClass = C_BEQ;
      OP_BNE: iClass = ENABLE_BNE ? C_BNE : C_ILLEGAL;
      OP_J:   iClass = C_J;
      OP_JAL: iClass = C_JAL;
      default: iClass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS controller: steps each instruction through IF..WB (3-5 cycles
// zero-wait), holds memory requests until mem_ready and halts on a wait timeout.
module multi_cycle_control
  import mcc_pkg::*;
#(
  parameter bit ENABLE_BNE  = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src1,
  output logic [1:0]       alu_src2,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             lu_op,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state, stateNext;
  iclass_t           iClass;
  logic              extOp, luOp, isShift;
  logic [WAIT_W-1:0] waitCnt;
  logic              memState, timeout, retire;
  ctrl_t             ctrl, ctrlOut;

  mcc_decode #(.ENABLE_BNE(ENABLE_BNE)) u_decode (
    .OpCode (OpCode),
    .Funct  (Funct),
    .iClass (iClass),
    .extOp  (extOp),
    .luOp   (luOp),
    .isShift(isShift)
  );

  assign memState = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout  = (MEM_TIMEOUT > 0) && memState && !mem_ready && (waitCnt == WAIT_LAST);
  assign retire   = (state == S_WB_R) || (state == S_WB_I) || (state == S_WB_LD) ||
                    (state == S_BR) || (state == S_J) || (state == S_JR) ||
                    ((state == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IF;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IF: begin
        if (timeout)        stateNext = S_HALT;
        else if (mem_ready) stateNext = S_ID;
      end
      S_ID: begin
        case (iClass)
          C_LW, C_SW:    stateNext = S_ADDR;
          C_RTYPE:       stateNext = S_EX_R;
          C_JR, C_JALR:  stateNext = S_JR;
          C_IALU:        stateNext = S_EX_I;
          C_BEQ, C_BNE:  stateNext = S_BR;
          C_J, C_JAL:    stateNext = S_J;
          default:       stateNext = S_IF;
        endcase
      end
      S_EX_R:  stateNext = S_WB_R;
      S_EX_I:  stateNext = S_WB_I;
      S_ADDR:  stateNext = (iClass == C_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (timeout)        stateNext = S_HALT;
        else if (mem_ready) stateNext = S_WB_LD;
      end
      S_MEM_WR: begin
        if (timeout)        stateNext = S_HALT;
        else if (mem_ready) stateNext = S_IF;
      end
      S_HALT:  stateNext = S_HALT;
      default: stateNext = S_IF;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu_src2 = B_FOUR;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      S_ID: begin
        ctrl.alu_src2 = B_IMMSH;
        ctrl.ext_op   = 1'b1;
        ctrl.illegal  = (iClass == C_ILLEGAL);
      end
      S_EX_R: begin
        ctrl.alu_src1 = isShift ? A_SHAMT : A_RS;
        ctrl.alu_op   = ALU_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RD;
      end
      S_EX_I: begin
        ctrl.alu_src1 = A_RS;
        ctrl.alu_src2 = B_IMM;
        ctrl.alu_op   = ALU_OPCODE;
        ctrl.ext_op   = extOp;
        ctrl.lu_op    = luOp;
      end
      S_WB_I: ctrl.reg_write = 1'b1;
      S_ADDR: begin
        ctrl.alu_src1 = A_RS;
        ctrl.alu_src2 = B_IMM;
        ctrl.ext_op   = 1'b1;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_WB_LD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_BR: begin
        ctrl.alu_src1 = A_RS;
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_src   = PC_ALUOUT;
        ctrl.pc_write = (iClass == C_BNE) ? !Zero : Zero;
      end
      S_J: begin
        // PC already holds PC+4, so jal links straight from PC
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
        if (iClass == C_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = DST_RA;
          ctrl.mem_to_reg = WB_PC;
        end
      end
      S_JR: begin
        ctrl.pc_src   = PC_RS;
        ctrl.pc_write = 1'b1;
        if (iClass == C_JALR) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = DST_RD;
          ctrl.mem_to_reg = WB_PC;
        end
      end
      default: ctrl = '0;
    endcase
  end

  // Gate with reset so an in-flight request drops as soon as rst_n falls
  assign ctrlOut    = rst_n ? ctrl : '0;
  assign mem_read   = ctrlOut.mem_read;
  assign mem_write  = ctrlOut.mem_write;
  assign i_or_d     = ctrlOut.i_or_d;
  assign ir_write   = ctrlOut.ir_write;
  assign pc_write   = ctrlOut.pc_write;
  assign pc_src     = ctrlOut.pc_src;
  assign reg_write  = ctrlOut.reg_write;
  assign reg_dst    = ctrlOut.reg_dst;
  assign mem_to_reg = ctrlOut.mem_to_reg;
  assign alu_src1   = ctrlOut.alu_src1;
  assign alu_src2   = ctrlOut.alu_src2;
  assign alu_op     = ctrlOut.alu_op;
  assign ext_op     = ctrlOut.ext_op;
  assign lu_op      = ctrlOut.lu_op;
  assign illegal    = ctrlOut.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt   <= '0;
      bus_err   <= 1'b0;
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      waitCnt <= (memState && (stateNext == state)) ? waitCnt + 1'b1 : '0;
      if (timeout)          bus_err   <= 1'b1;
      if (retire)           instr_cnt <= instr_cnt + CNT_W'(1);
      if (state != S_HALT)  cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: instruction vector table with a latency/result
// scoreboard, plus hand sequences for bne-disabled, timeout and async reset.
module tb_multi_cycle_control;
  import mcc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rstNb_n;
  logic [5:0]  OpCode, Funct;
  logic        Zero, mem_ready, nbReady;

  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src1, alu_src2, alu_op;
  logic        ext_op, lu_op, illegal, bus_err;
  logic [31:0] instr_cnt, cycle_cnt;

  logic        nb_mem_read, nb_mem_write, nb_i_or_d, nb_ir_write, nb_pc_write, nb_reg_write;
  logic [1:0]  nb_pc_src, nb_reg_dst, nb_mem_to_reg, nb_alu_src1, nb_alu_src2, nb_alu_op;
  logic        nb_ext_op, nb_lu_op, nb_illegal, nb_bus_err;
  logic [31:0] nb_instr_cnt, nb_cycle_cnt;

  ctrl_t act, nbAct;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         dly;
    int         lat;
    int         probeIdx;
    ctrl_t      probe;
    ctrl_t      last;
    int         dCnt;
  } vec_t;

  typedef struct {
    int    idx;
    int    lat;
    ctrl_t last;
    int    dCnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   nTests = 0;
  int   nFail  = 0;
  int   waitLeft = 0;

  always #5 clk = ~clk;

  multi_cycle_control #(.ENABLE_BNE(1'b1), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_op(alu_op), .ext_op(ext_op), .lu_op(lu_op), .illegal(illegal), .bus_err(bus_err),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  multi_cycle_control #(.ENABLE_BNE(1'b0), .MEM_TIMEOUT(16), .CNT_W(32)) dutNb (
    .clk(clk), .rst_n(rstNb_n), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(nbReady), .mem_read(nb_mem_read), .mem_write(nb_mem_write), .i_or_d(nb_i_or_d),
    .ir_write(nb_ir_write), .pc_write(nb_pc_write), .pc_src(nb_pc_src), .reg_write(nb_reg_write),
    .reg_dst(nb_reg_dst), .mem_to_reg(nb_mem_to_reg), .alu_src1(nb_alu_src1), .alu_src2(nb_alu_src2),
    .alu_op(nb_alu_op), .ext_op(nb_ext_op), .lu_op(nb_lu_op), .illegal(nb_illegal),
    .bus_err(nb_bus_err), .instr_cnt(nb_instr_cnt), .cycle_cnt(nb_cycle_cnt)
  );

  always_comb begin
    act = '0;
    act.mem_read = mem_read;     act.mem_write = mem_write;   act.i_or_d = i_or_d;
    act.ir_write = ir_write;     act.pc_write = pc_write;     act.pc_src = pc_src;
    act.reg_write = reg_write;   act.reg_dst = reg_dst;       act.mem_to_reg = mem_to_reg;
    act.alu_src1 = alu_src1;     act.alu_src2 = alu_src2;     act.alu_op = alu_op;
    act.ext_op = ext_op;         act.lu_op = lu_op;           act.illegal = illegal;
  end

  always_comb begin
    nbAct = '0;
    nbAct.mem_read = nb_mem_read;   nbAct.mem_write = nb_mem_write; nbAct.i_or_d = nb_i_or_d;
    nbAct.ir_write = nb_ir_write;   nbAct.pc_write = nb_pc_write;   nbAct.pc_src = nb_pc_src;
    nbAct.reg_write = nb_reg_write; nbAct.reg_dst = nb_reg_dst;     nbAct.mem_to_reg = nb_mem_to_reg;
    nbAct.alu_src1 = nb_alu_src1;   nbAct.alu_src2 = nb_alu_src2;   nbAct.alu_op = nb_alu_op;
    nbAct.ext_op = nb_ext_op;       nbAct.lu_op = nb_lu_op;         nbAct.illegal = nb_illegal;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Unified memory model: data accesses stall for waitLeft cycles, fetches never do
  task automatic resp();
    if ((mem_read || mem_write) && i_or_d) begin
      if (waitLeft > 0) begin
        mem_ready = 1'b0;
        waitLeft--;
      end else begin
        mem_ready = 1'b1;
      end
    end else begin
      mem_ready = mem_read || mem_write;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1 resp();
    #1;
  endtask

  task automatic addV(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int dly, input int lat, input int pi,
                      input ctrl_t pr, input ctrl_t la, input int d);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.dly = dly; v.lat = lat;
    v.probeIdx = pi; v.probe = pr; v.last = la; v.dCnt = d;
    tbl.push_back(v);
  endtask

  // Called while the DUT sits in a fetch cycle, sampled before the clock edge
  task automatic runInstr(input int idx);
    vec_t        v;
    exp_t        e;
    ctrl_t       lastC;
    logic [31:0] i0, c0;
    int          n;
    bit          done;
    v = tbl[idx];
    OpCode = v.op; Funct = v.fn; Zero = v.z; waitLeft = v.dly;
    #1 resp();
    #1;
    sb.push_back('{idx: idx, lat: v.lat, last: v.last, dCnt: v.dCnt});
    i0 = instr_cnt; c0 = cycle_cnt;
    n = 0; done = 1'b0; lastC = '0;
    while (!done) begin
      if (n == v.probeIdx) check($sformatf("v%0d_probe", idx), 32'(act), 32'(v.probe));
      lastC = act;
      step();
      n++;
      if (mem_read && !i_or_d) done = 1'b1;
      else if (n > 40)         done = 1'b1;
    end
    e = sb.pop_front();
    check($sformatf("v%0d_latency", e.idx), 32'(n), 32'(e.lat));
    check($sformatf("v%0d_last_ctrl", e.idx), 32'(lastC), 32'(e.last));
    check($sformatf("v%0d_instr_delta", e.idx), instr_cnt - i0, 32'(e.dCnt));
    check($sformatf("v%0d_cycle_delta", e.idx), cycle_cnt - c0, 32'(e.lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_t cIfGo, cIfIdle, cId, cWbr, cWbi, cExi, cMem, cLd, cSt, cAddr, cBrT, cBrN;
    ctrl_t cJ, cJal, cJr, cJalr, cIll;
    int k;
    logic [31:0] c1;

    cIfGo   = '{mem_read: 1'b1, ir_write: 1'b1, pc_write: 1'b1, alu_src2: 2'b01, default: '0};
    cIfIdle = '{mem_read: 1'b1, alu_src2: 2'b01, default: '0};
    cId     = '{alu_src2: 2'b11, ext_op: 1'b1, default: '0};
    cWbr    = '{reg_write: 1'b1, reg_dst: 2'b01, default: '0};
    cWbi    = '{reg_write: 1'b1, default: '0};
    cExi    = '{alu_src1: 2'b01, alu_src2: 2'b10, alu_op: 2'b11, ext_op: 1'b1, default: '0};
    cMem    = '{mem_read: 1'b1, i_or_d: 1'b1, default: '0};
    cLd     = '{reg_write: 1'b1, mem_to_reg: 2'b01, default: '0};
    cSt     = '{mem_write: 1'b1, i_or_d: 1'b1, default: '0};
    cAddr   = '{alu_src1: 2'b01, alu_src2: 2'b10, ext_op: 1'b1, default: '0};
    cBrT    = '{alu_src1: 2'b01, alu_op: 2'b01, pc_src: 2'b01, pc_write: 1'b1, default: '0};
    cBrN    = '{alu_src1: 2'b01, alu_op: 2'b01, pc_src: 2'b01, default: '0};
    cJ      = '{pc_src: 2'b10, pc_write: 1'b1, default: '0};
    cJal    = '{pc_src: 2'b10, pc_write: 1'b1, reg_write: 1'b1, reg_dst: 2'b10, mem_to_reg: 2'b10, default: '0};
    cJr     = '{pc_src: 2'b11, pc_write: 1'b1, default: '0};
    cJalr   = '{pc_src: 2'b11, pc_write: 1'b1, reg_write: 1'b1, reg_dst: 2'b01, mem_to_reg: 2'b10, default: '0};
    cIll    = '{alu_src2: 2'b11, ext_op: 1'b1, illegal: 1'b1, default: '0};

    //   op     fn     z  dly lat probe probeCtrl                                      last   dCnt
    addV(6'h00, 6'h20, 0, 0, 4, 2, '{alu_src1: 2'b01, alu_op: 2'b10, default: '0}, cWbr, 1); // add
    addV(6'h00, 6'h00, 0, 0, 4, 2, '{alu_src1: 2'b10, alu_op: 2'b10, default: '0}, cWbr, 1); // sll
    addV(6'h08, 6'h00, 0, 0, 4, 2, cExi, cWbi, 1);                                           // addi
    addV(6'h0C, 6'h00, 0, 0, 4, 2, '{alu_src1: 2'b01, alu_src2: 2'b10, alu_op: 2'b11, default: '0}, cWbi, 1); // andi
    addV(6'h0F, 6'h00, 0, 0, 4, 2, '{alu_src1: 2'b01, alu_src2: 2'b10, alu_op: 2'b11, ext_op: 1'b1, lu_op: 1'b1, default: '0}, cWbi, 1); // lui
    addV(6'h23, 6'h00, 0, 0, 5, 3, cMem, cLd, 1);                                           // lw
    addV(6'h23, 6'h00, 0, 3, 8, 5, cMem, cLd, 1);                                           // lw, 3 waits
    addV(6'h2B, 6'h00, 0, 0, 4, 2, cAddr, cSt, 1);                                          // sw
    addV(6'h2B, 6'h00, 0, 2, 6, 0, cIfGo, cSt, 1);                                          // sw, 2 waits
    addV(6'h04, 6'h00, 1, 0, 3, 1, cId, cBrT, 1);                                           // beq taken
    addV(6'h04, 6'h00, 0, 0, 3, 1, cId, cBrN, 1);                                           // beq not taken
    addV(6'h05, 6'h00, 1, 0, 3, 1, cId, cBrN, 1);                                           // bne not taken
    addV(6'h05, 6'h00, 0, 0, 3, 1, cId, cBrT, 1);                                           // bne taken
    addV(6'h02, 6'h00, 0, 0, 3, 0, cIfGo, cJ, 1);                                           // j
    addV(6'h03, 6'h00, 0, 0, 3, 0, cIfGo, cJal, 1);                                         // jal
    addV(6'h00, 6'h08, 0, 0, 3, 0, cIfGo, cJr, 1);                                          // jr
    addV(6'h00, 6'h09, 0, 0, 3, 0, cIfGo, cJalr, 1);                                        // jalr
    addV(6'h3F, 6'h00, 0, 0, 2, 0, cIfGo, cIll, 0);                                         // illegal
    addV(6'h00, 6'h22, 0, 0, 4, 1, cId, cWbr, 1);                                           // sub after illegal

    rst_n = 1'b0; rstNb_n = 1'b0;
    OpCode = 6'h00; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b0; nbReady = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", 32'(act), 32'h0);
    check("reset_instr_cnt", instr_cnt, 32'h0);
    check("reset_cycle_cnt", cycle_cnt, 32'h0);
    check("reset_bus_err", 32'(bus_err), 32'h0);
    check("nb_reset_all", 32'(nbAct) | nb_instr_cnt | nb_cycle_cnt | 32'(nb_bus_err), 32'h0);

    // bne on the ENABLE_BNE=0 build must be rejected in decode
    OpCode = 6'h05; nbReady = 1'b1;
    @(negedge clk) rstNb_n = 1'b1;
    #1 check("nb_fetch", 32'(nbAct), 32'(cIfGo));
    @(negedge clk); #1;
    check("nb_bne_illegal", 32'(nb_illegal), 32'h1);
    @(negedge clk); #1;
    check("nb_illegal_pulse_end", 32'(nb_illegal), 32'h0);
    check("nb_back_to_fetch", 32'({nb_mem_read, nb_i_or_d}), 32'h2);
    check("nb_instr_cnt", nb_instr_cnt, 32'h0);
    check("main_held_in_reset", 32'(act), 32'h0);

    @(negedge clk) rst_n = 1'b1;
    #1 check("post_reset_fetch", 32'(act), 32'(cIfIdle));

    for (int i = 0; i < tbl.size(); i++) runInstr(i);

    // Data read that never completes
    OpCode = 6'h23; Funct = 6'h00; waitLeft = 1000;
    #1 resp();
    #1;
    k = 0;
    while (!(mem_read && i_or_d) && k < 10) begin step(); k++; end
    check("to_reached_mem_rd", 32'(k), 32'd3);
    check("to_bus_err_idle", 32'(bus_err), 32'h0);
    k = 0;
    while (mem_read && i_or_d && k < 40) begin step(); k++; end
    check("to_wait_cycles", 32'(k), 32'd16);
    check("to_bus_err", 32'(bus_err), 32'h1);
    check("halt_ctrl", 32'(act), 32'h0);
    c1 = cycle_cnt;
    repeat (3) step();
    check("halt_cycle_frozen", cycle_cnt, c1);
    check("halt_ctrl_held", 32'(act), 32'h0);

    #1 rst_n = 1'b0; mem_ready = 1'b0;
    #1 check("halt_reset_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Store stalled in memory, then reset asserted between clock edges
    OpCode = 6'h2B; waitLeft = 1000;
    #1 resp();
    #1;
    k = 0;
    while (!mem_write && k < 10) begin step(); k++; end
    check("sw_reached_mem_wr", 32'(k), 32'd3);
    repeat (2) step();
    check("sw_still_waiting", 32'(act), 32'(cSt));
    #1 rst_n = 1'b0;
    #1 check("async_reset_ctrl", 32'(act), 32'h0);
    check("async_reset_cnts", instr_cnt | cycle_cnt, 32'h0);
    mem_ready = 1'b0; waitLeft = 0;
    @(negedge clk) rst_n = 1'b1;
    #1 check("restart_fetch", 32'(act), 32'(cIfIdle));
    runInstr(0);
    check("restart_instr_cnt", instr_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle MIPS controller FSM; successor to the single-cycle combinational decoder.
- Sequences each instruction through IF/ID/EX/MEM/WB and drives datapath enables per cycle.
- Handshakes with a variable-latency unified memory and flags illegal opcodes and memory timeouts.
- Adds optional bne support and instruction/cycle counters.

Parameters:
- ENABLE_BNE, 1: decode opcode 6'h05 as bne; when 0, opcode 6'h05 is illegal.
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready before raising bus_err; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction and cycle counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- OpCode  in  6  IR[31:26]; valid from the cycle after ir_write.
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, valid in the branch state.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR and MDR.
- pc_write  out  1  unconditional PC load.
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut (branch target), 10 = jump target, 11 = rs.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31.
- mem_to_reg  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC.
- alu_src1  out  2  ALU operand A: 00 = PC, 01 = rs, 10 = shamt.
- alu_src2  out  2  ALU operand B: 00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode Funct, 11 = decode OpCode.
- ext_op  out  1  sign-extend immediate (0 only for andi).
- lu_op  out  1  lui
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- bus_err  out  1  sticky; cleared only by reset.
- instr_cnt  out  CNT_W  retired instructions
- cycle_cnt  out  CNT_W  cycles since reset

Behaviour:
- Reset (async on rst_n low):
  - State goes to S_IF.
  - All outputs 0, counters 0, bus_err 0.
  - Reset asserted mid-access drops mem_read/mem_write immediately.
- Outputs are Moore, decoded from the state register plus registered OpCode/Funct. No output depends combinationally on mem_ready or Zero, except as noted for S_BR and the memory states.
- S_IF:
  - mem_read=1, i_or_d=0, alu_src1=00, alu_src2=01, alu_op=00, pc_src=00.
  - Requests are held stable until mem_ready=1.
  - In the mem_ready cycle, ir_write=1 and pc_write=1, then go to S_ID.
- S_ID:
  - alu_src1=00, alu_src2=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - lw/sw → S_ADDR
    - R-type → S_EX_R (jr/jalr → S_JR)
    - lui/addi/addiu/andi/slti/sltiu → S_EX_I
    - beq/bne → S_BR
    - j/jal → S_J
    - anything else: illegal=1, go to S_IF.
- S_EX_R:
  - alu_src1=10 for sll/srl/sra (Funct 00/02/03), otherwise 01.
  - alu_src2=00, alu_op=10, then go to S_WB_R.
- S_WB_R: reg_write=1, reg_dst=01, mem_to_reg=00, then go to S_IF.
- S_EX_I:
  - alu_src1=01, alu_src2=10, alu_op=11; ext_op and lu_op driven.
  - Then go to S_WB_I: reg_write=1, reg_dst=00, then go to S_IF.
- S_ADDR: alu_src1=01, alu_src2=10, alu_op=00, then go to S_MEM_RD (lw) or S_MEM_WR (sw).
- S_MEM_RD: mem_read=1, i_or_d=1, ir_write=0. On mem_ready, go to S_WB_LD: reg_write=1, reg_dst=00, mem_to_reg=01.
- S_MEM_WR: mem_write=1, i_or_d=1. On mem_ready, go to S_IF.
- S_BR:
  - alu_src1=01, alu_src2=00, alu_op=01, pc_src=01.
  - pc_write = Zero for beq, !Zero for bne (combinational on Zero).
  - Then go to S_IF.
- S_J: pc_src=10, pc_write=1. For jal also reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). Then go to S_IF.
- S_JR: pc_src=11, pc_write=1. For jalr also reg_write=1, reg_dst=01, mem_to_reg=10. Then go to S_IF.
- Memory timeout:
  - Wait counter resets on entry to each memory state and increments each cycle without mem_ready.
  - At MEM_TIMEOUT: bus_err=1, drop the request, go to S_HALT.
  - S_HALT: all enables 0; held until reset.
- Counters:
  - cycle_cnt increments every cycle except in S_HALT.
  - instr_cnt increments on the last cycle of each legal instruction; illegal instructions are not counted.
  - Both wrap modulo 2^CNT_W.
- Zero-wait latencies (mem_ready=1 on first request cycle):
  - R-type/I-ALU 4 cycles; lw 5; sw 4; beq/bne 3; j/jal/jr/jalr 3.

Decomposition:
- Package mcc_pkg holds:
  - State enum.
  - Opcode/funct localparams.
  - Encodings for pc_src, reg_dst, mem_to_reg, alu_src1, alu_src2, alu_op.
- One sub-module, mcc_decode: combinational OpCode/Funct → instruction class plus ext_op/lu_op/shift flags. The FSM and counters stay in the top.

Test Plan:
- add (OpCode 0, Funct 6'h20), mem_ready tied 1 → states IF,ID,EX_R,WB_R; reg_write=1, reg_dst=01 in cycle 4; instr_cnt 0→1.
- lw with mem_ready low for 3 cycles in S_MEM_RD → mem_read and i_or_d=1 held 4 cycles; WB_LD asserts mem_to_reg=01; total 8 cycles.
- beq with Zero=1, then Zero=0 → pc_write=1 with pc_src=01 in S_BR, then pc_write=0; ENABLE_BNE=1 bne shows the inverse.
- jal → S_J drives pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10 in one cycle.
- OpCode 6'h3F, and bne with ENABLE_BNE=0 → illegal pulses 1 cycle in S_ID, next state S_IF, instr_cnt unchanged.
- mem_ready held 0 with MEM_TIMEOUT=16 → bus_err rises after 16 waiting cycles, then S_HALT; cycle_cnt frozen. Then rst_n low mid-S_MEM_WR → all outputs 0 asynchronously, restart in S_IF.
